// File: rtl/cpu_controller.sv
// ============================================================================
// Module   : cpu_controller
// Function : Instruction register plus Moore control FSM for a simple datapath
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module cpu_controller (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [15:0] instr_in,
    input  logic        load_ir,
    input  logic        s,
    output logic        w,
    output logic [2:0]  readnum,
    output logic [2:0]  writenum,
    output logic        write,
    output logic        loada,
    output logic        loadb,
    output logic        loadc,
    output logic        loads,
    output logic        asel,
    output logic        bsel,
    output logic [1:0]  vsel,
    output logic [1:0]  shift,
    output logic [1:0]  ALUop,
    output logic [15:0] sximm8,
    output logic [15:0] sximm5
);

    localparam logic [2:0] c_ST_WAIT   = 3'd0;
    localparam logic [2:0] c_ST_DECODE = 3'd1;
    localparam logic [2:0] c_ST_WIMM   = 3'd2;
    localparam logic [2:0] c_ST_GETA   = 3'd3;
    localparam logic [2:0] c_ST_GETB   = 3'd4;
    localparam logic [2:0] c_ST_ALU    = 3'd5;
    localparam logic [2:0] c_ST_CMPS   = 3'd6;
    localparam logic [2:0] c_ST_WREG   = 3'd7;

    logic [2:0]  r_state;
    logic [2:0]  w_next_state;
    logic [15:0] r_ir;

    logic [2:0] w_opcode;
    logic [1:0] w_op;
    logic [2:0] w_rn;
    logic [2:0] w_rd;
    logic [1:0] w_sh;
    logic [2:0] w_rm;
    logic       w_is_movi;
    logic       w_is_movr;
    logic       w_is_mvn;
    logic       w_is_cmp;
    logic       w_is_two_src;
    logic [1:0] w_alu_op;

    assign w_opcode = r_ir[15:13];
    assign w_op     = r_ir[12:11];
    assign w_rn     = r_ir[10:8];
    assign w_rd     = r_ir[7:5];
    assign w_sh     = r_ir[4:3];
    assign w_rm     = r_ir[2:0];

    assign w_is_movi    = (w_opcode == 3'b110) && (w_op == 2'b10);
    assign w_is_movr    = (w_opcode == 3'b110) && (w_op == 2'b00);
    assign w_is_mvn     = (w_opcode == 3'b101) && (w_op == 2'b11);
    assign w_is_cmp     = (w_opcode == 3'b101) && (w_op == 2'b01);
    assign w_is_two_src = (w_opcode == 3'b101) && (w_op != 2'b11);
    // ALU-class op field already matches the ALUop encoding; MOV uses add with A forced to zero.
    assign w_alu_op     = (w_opcode == 3'b101) ? w_op : 2'b00;

    assign sximm8 = {{8{r_ir[7]}}, r_ir[7:0]};
    assign sximm5 = {{11{r_ir[4]}}, r_ir[4:0]};

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state <= c_ST_WAIT;
            r_ir    <= 16'h0000;
        end else begin
            r_state <= w_next_state;
            if (load_ir && (r_state == c_ST_WAIT))
                r_ir <= instr_in;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            c_ST_WAIT:   if (s) w_next_state = c_ST_DECODE;
            c_ST_DECODE: begin
                if (w_is_movi)                  w_next_state = c_ST_WIMM;
                else if (w_is_movr || w_is_mvn) w_next_state = c_ST_GETB;
                else if (w_is_two_src)          w_next_state = c_ST_GETA;
                else                            w_next_state = c_ST_WAIT;
            end
            c_ST_GETA:   w_next_state = c_ST_GETB;
            c_ST_GETB:   w_next_state = w_is_cmp ? c_ST_CMPS : c_ST_ALU;
            c_ST_ALU:    w_next_state = c_ST_WREG;
            default:     w_next_state = c_ST_WAIT;
        endcase
    end

    always_comb begin
        w        = 1'b0;
        readnum  = 3'b000;
        writenum = 3'b000;
        write    = 1'b0;
        loada    = 1'b0;
        loadb    = 1'b0;
        loadc    = 1'b0;
        loads    = 1'b0;
        asel     = 1'b0;
        bsel     = 1'b0;
        vsel     = 2'b00;
        shift    = 2'b00;
        ALUop    = 2'b00;
        case (r_state)
            c_ST_WAIT: w = 1'b1;
            c_ST_WIMM: begin
                write    = 1'b1;
                vsel     = 2'b10;
                writenum = w_rn;
            end
            c_ST_GETA: begin
                readnum = w_rn;
                loada   = 1'b1;
            end
            c_ST_GETB: begin
                readnum = w_rm;
                loadb   = 1'b1;
            end
            c_ST_ALU: begin
                loadc = 1'b1;
                shift = w_sh;
                asel  = w_is_movr;
                ALUop = w_alu_op;
            end
            c_ST_CMPS: begin
                loads = 1'b1;
                shift = w_sh;
                ALUop = 2'b01;
            end
            c_ST_WREG: begin
                write    = 1'b1;
                writenum = w_rd;
            end
            default: ;
        endcase
    end

endmodule

`default_nettype wire

// File: tb/tb_cpu_controller.sv
// ============================================================================
// Module   : tb_cpu_controller
// Function : Directed self-checking bench for cpu_controller
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_cpu_controller;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [15:0] instr_in;
    logic        load_ir;
    logic        s;
    logic        w;
    logic [2:0]  readnum;
    logic [2:0]  writenum;
    logic        write;
    logic        loada;
    logic        loadb;
    logic        loadc;
    logic        loads;
    logic        asel;
    logic        bsel;
    logic [1:0]  vsel;
    logic [1:0]  shift;
    logic [1:0]  ALUop;
    logic [15:0] sximm8;
    logic [15:0] sximm5;

    integer errors = 0;
    integer checks = 0;

    always #5 clk = ~clk;

    cpu_controller dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .instr_in (instr_in),
        .load_ir  (load_ir),
        .s        (s),
        .w        (w),
        .readnum  (readnum),
        .writenum (writenum),
        .write    (write),
        .loada    (loada),
        .loadb    (loadb),
        .loadc    (loadc),
        .loads    (loads),
        .asel     (asel),
        .bsel     (bsel),
        .vsel     (vsel),
        .shift    (shift),
        .ALUop    (ALUop),
        .sximm8   (sximm8),
        .sximm5   (sximm5)
    );

    // Packed view of every control output: {w,readnum,writenum,write,loada,loadb,loadc,loads,asel,bsel,vsel,shift,ALUop}
    logic [19:0] ctl;
    assign ctl = {w, readnum, writenum, write, loada, loadb, loadc, loads,
                  asel, bsel, vsel, shift, ALUop};

    function automatic logic [19:0] mk(input logic e_w, input logic [2:0] e_rn,
                                       input logic [2:0] e_wn, input logic e_wr,
                                       input logic e_la, input logic e_lb,
                                       input logic e_lc, input logic e_ls,
                                       input logic e_as, input logic e_bs,
                                       input logic [1:0] e_vs, input logic [1:0] e_sh,
                                       input logic [1:0] e_op);
        return {e_w, e_rn, e_wn, e_wr, e_la, e_lb, e_lc, e_ls, e_as, e_bs, e_vs, e_sh, e_op};
    endfunction

    logic [19:0] idle_c, decode_c;
    initial begin
        idle_c   = mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00);
        decode_c = 20'h00000;
    end

    // Presents an instruction with load_ir and s for one edge; returns at the next negedge.
    task automatic start(input logic [15:0] instr);
        instr_in = instr;
        load_ir  = 1'b1;
        s        = 1'b1;
        @(negedge clk);
        load_ir  = 1'b0;
        s        = 1'b0;
    endtask

    task automatic test_reset;
        reset_n  = 1'b0;
        instr_in = 16'hFFFF;
        load_ir  = 1'b1;
        s        = 1'b1;
        @(negedge clk);
        @(negedge clk);
        load_ir  = 1'b0;
        s        = 1'b0;
        reset_n  = 1'b1;
        checks++;
        if (ctl !== idle_c) begin
            errors++;
            $display("FAIL reset_ctl: got %h expected %h", ctl, idle_c);
        end
        checks++;
        if (sximm8 !== 16'h0000) begin
            errors++;
            $display("FAIL reset_sximm8: got %h expected 0000", sximm8);
        end
        checks++;
        if (sximm5 !== 16'h0000) begin
            errors++;
            $display("FAIL reset_sximm5: got %h expected 0000", sximm5);
        end
    endtask

    task automatic test_mov_imm;
        logic [19:0] exp_seq [3];
        exp_seq[0] = decode_c;
        exp_seq[1] = mk(0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 2'b10, 2'b00, 2'b00);
        exp_seq[2] = idle_c;
        start(16'hD0FF);
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (ctl !== exp_seq[i]) begin
                errors++;
                $display("FAIL movi_step%0d: got %h expected %h", i, ctl, exp_seq[i]);
            end
            if (i == 1) begin
                checks++;
                if (sximm8 !== 16'hFFFF) begin
                    errors++;
                    $display("FAIL movi_sximm8: got %h expected ffff", sximm8);
                end
                checks++;
                if (sximm5 !== 16'hFFFF) begin
                    errors++;
                    $display("FAIL movi_sximm5: got %h expected ffff", sximm5);
                end
            end
            if (i < 2) @(negedge clk);
        end
    endtask

    task automatic test_add;
        logic [19:0] exp_seq [6];
        exp_seq[0] = decode_c;
        exp_seq[1] = mk(0, 1, 0, 0, 1, 0, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00);
        exp_seq[2] = mk(0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00);
        exp_seq[3] = mk(0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 2'b00, 2'b01, 2'b00);
        exp_seq[4] = mk(0, 0, 2, 1, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00);
        exp_seq[5] = idle_c;
        start(16'hA148);
        for (int i = 0; i < 6; i++) begin
            checks++;
            if (ctl !== exp_seq[i]) begin
                errors++;
                $display("FAIL add_step%0d: got %h expected %h", i, ctl, exp_seq[i]);
            end
            if (i < 5) @(negedge clk);
        end
    endtask

    task automatic test_cmp;
        logic [19:0] exp_seq [5];
        exp_seq[0] = decode_c;
        exp_seq[1] = mk(0, 1, 0, 0, 1, 0, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00);
        exp_seq[2] = mk(0, 2, 0, 0, 0, 1, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00);
        exp_seq[3] = mk(0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 2'b00, 2'b00, 2'b01);
        exp_seq[4] = idle_c;
        start(16'hA902);
        for (int i = 0; i < 5; i++) begin
            checks++;
            if (ctl !== exp_seq[i]) begin
                errors++;
                $display("FAIL cmp_step%0d: got %h expected %h", i, ctl, exp_seq[i]);
            end
            if (i < 4) @(negedge clk);
        end
    endtask

    task automatic test_mvn;
        logic [19:0] exp_seq [5];
        exp_seq[0] = decode_c;
        exp_seq[1] = mk(0, 1, 0, 0, 0, 1, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00);
        exp_seq[2] = mk(0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 2'b00, 2'b00, 2'b11);
        exp_seq[3] = mk(0, 0, 3, 1, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00);
        exp_seq[4] = idle_c;
        start(16'hB861);
        for (int i = 0; i < 5; i++) begin
            checks++;
            if (ctl !== exp_seq[i]) begin
                errors++;
                $display("FAIL mvn_step%0d: got %h expected %h", i, ctl, exp_seq[i]);
            end
            if (i < 4) @(negedge clk);
        end
    endtask

    // MOV R5,R1 (0xC0A1): A operand forced to zero in ALU
    task automatic test_mov_reg;
        logic [19:0] exp_seq [5];
        exp_seq[0] = decode_c;
        exp_seq[1] = mk(0, 1, 0, 0, 0, 1, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00);
        exp_seq[2] = mk(0, 0, 0, 0, 0, 0, 1, 0, 1, 0, 2'b00, 2'b00, 2'b00);
        exp_seq[3] = mk(0, 0, 5, 1, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00);
        exp_seq[4] = idle_c;
        start(16'hC0A1);
        for (int i = 0; i < 5; i++) begin
            checks++;
            if (ctl !== exp_seq[i]) begin
                errors++;
                $display("FAIL movr_step%0d: got %h expected %h", i, ctl, exp_seq[i]);
            end
            if (i < 4) @(negedge clk);
        end
    endtask

    task automatic test_illegal;
        start(16'h0000);
        checks++;
        if (ctl !== decode_c) begin
            errors++;
            $display("FAIL illegal_decode: got %h expected %h", ctl, decode_c);
        end
        @(negedge clk);
        checks++;
        if (ctl !== idle_c) begin
            errors++;
            $display("FAIL illegal_wait: got %h expected %h", ctl, idle_c);
        end
    endtask

    task automatic test_reset_mid;
        logic [19:0] alu_c;
        alu_c = mk(0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 2'b00, 2'b01, 2'b00);
        start(16'hA148);
        @(negedge clk);
        @(negedge clk);
        @(negedge clk);
        checks++;
        if (ctl !== alu_c) begin
            errors++;
            $display("FAIL rstmid_alu: got %h expected %h", ctl, alu_c);
        end
        reset_n = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        checks++;
        if (ctl !== idle_c) begin
            errors++;
            $display("FAIL rstmid_ctl: got %h expected %h", ctl, idle_c);
        end
        checks++;
        if ({sximm8, sximm5} !== 32'h0) begin
            errors++;
            $display("FAIL rstmid_ir: got %h expected 00000000", {sximm8, sximm5});
        end
        @(negedge clk);
        checks++;
        if (ctl !== idle_c) begin
            errors++;
            $display("FAIL rstmid_no_write: got %h expected %h", ctl, idle_c);
        end
    endtask

    task automatic test_ignore_midflight;
        logic [19:0] exp_seq [6];
        exp_seq[0] = decode_c;
        exp_seq[1] = mk(0, 1, 0, 0, 1, 0, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00);
        exp_seq[2] = mk(0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00);
        exp_seq[3] = mk(0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 2'b00, 2'b01, 2'b00);
        exp_seq[4] = mk(0, 0, 2, 1, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00);
        exp_seq[5] = idle_c;
        start(16'hA148);
        for (int i = 0; i < 6; i++) begin
            checks++;
            if (ctl !== exp_seq[i]) begin
                errors++;
                $display("FAIL ignore_step%0d: got %h expected %h", i, ctl, exp_seq[i]);
            end
            if (i == 1) begin
                instr_in = 16'hD001;
                load_ir  = 1'b1;
                s        = 1'b1;
            end else begin
                load_ir  = 1'b0;
                s        = 1'b0;
            end
            if (i < 5) @(negedge clk);
        end
        checks++;
        if (sximm8 !== 16'h0048) begin
            errors++;
            $display("FAIL ignore_sximm8: got %h expected 0048", sximm8);
        end
        checks++;
        if (sximm5 !== 16'h0008) begin
            errors++;
            $display("FAIL ignore_sximm5: got %h expected 0008", sximm5);
        end
    endtask

    task automatic test_back_to_back;
        logic [19:0] exp_seq [6];
        logic [19:0] wimm_c;
        wimm_c     = mk(0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 2'b10, 2'b00, 2'b00);
        exp_seq[0] = decode_c;
        exp_seq[1] = wimm_c;
        exp_seq[2] = idle_c;
        exp_seq[3] = decode_c;
        exp_seq[4] = wimm_c;
        exp_seq[5] = idle_c;
        instr_in = 16'hD0FF;
        load_ir  = 1'b1;
        s        = 1'b1;
        @(negedge clk);
        load_ir  = 1'b0;
        for (int i = 0; i < 6; i++) begin
            checks++;
            if (ctl !== exp_seq[i]) begin
                errors++;
                $display("FAIL b2b_step%0d: got %h expected %h", i, ctl, exp_seq[i]);
            end
            if (i == 3) s = 1'b0;
            if (i < 5) @(negedge clk);
        end
        @(negedge clk);
        checks++;
        if (ctl !== idle_c) begin
            errors++;
            $display("FAIL b2b_stays_idle: got %h expected %h", ctl, idle_c);
        end
    endtask

    initial begin
        reset_n  = 1'b0;
        instr_in = 16'h0000;
        load_ir  = 1'b0;
        s        = 1'b0;
        @(negedge clk);
        test_reset;
        test_mov_imm;
        test_add;
        test_cmp;
        test_mvn;
        test_mov_reg;
        test_illegal;
        test_reset_mid;
        test_ignore_midflight;
        test_back_to_back;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/cpu_controller.md
CPU_CONTROLLER -- requirements
Module: cpu_controller

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-low reset; ports SHALL be as listed in REQ-002 to REQ-017.
REQ-002 clk  in  1  rising-edge clock, shared with the datapath.
REQ-003 reset_n  in  1  synchronous active-low reset.
REQ-004 instr_in  in  16  instruction word to be captured.
REQ-005 load_ir  in  1  capture instr_in into IR; honoured only while w=1.
REQ-006 s  in  1  start execution of IR; honoured only while w=1.
REQ-007 w  out  1  idle/ready; high only in WAIT.
REQ-008 readnum, writenum  out  3 each  datapath register selects.
REQ-009 write  out  1  register-file write enable.
REQ-010 loada, loadb, loadc, loads  out  1 each  datapath register enables.
REQ-011 asel, bsel  out  1 each  A mux (1 = zero), B mux (1 = sximm5).
REQ-012 vsel  out  2  writeback select: 00 = C, 01 = PC, 10 = sximm8, 11 = mdata.
REQ-013 shift  out  2  shifter control, IR[4:3].
REQ-014 ALUop  out  2  00 = add, 01 = sub, 10 = and, 11 = not B.
REQ-015 sximm8  out  16  IR[7:0] sign-extended.
REQ-016 sximm5  out  16  IR[4:0] sign-extended.
REQ-017 All outputs SHALL be Moore: decoded from registered state and IR only, with no combinational path from any input.

Function
REQ-018 IR fields SHALL be: opcode[15:13], op[12:11], Rn[10:8], Rd[7:5], sh[4:3], Rm[2:0].
REQ-019 The FSM SHALL have states WAIT, DECODE, WIMM, GETA, GETB, ALU, CMPS, WREG.
REQ-020 Transitions SHALL be: WAIT -> DECODE when s=1.
REQ-021 From DECODE, opcode 110 / op 10 (MOV Rn,#imm8) SHALL go to WIMM.
REQ-022 From DECODE, opcode 110 / op 00 (MOV Rd,Rm) and 101 / op 11 (MVN) SHALL go to GETB.
REQ-023 From DECODE, opcode 101 / op 00, 01, 10 (ADD, CMP, AND) SHALL go to GETA.
REQ-024 From DECODE, any other encoding SHALL return to WAIT with no write, loads or loadc.
REQ-025 Following transitions SHALL be: GETA -> GETB; GETB -> ALU (ADD, AND, MOV, MVN) or CMPS (CMP); ALU -> WREG; WIMM, WREG and CMPS -> WAIT.
REQ-026 WIMM SHALL assert write=1, vsel=10, writenum=Rn.
REQ-027 GETA SHALL assert readnum=Rn, loada=1.
REQ-028 GETB SHALL assert readnum=Rm, loadb=1.
REQ-029 ALU SHALL assert loadc=1, bsel=0, shift=sh; asel=1 for MOV, else 0.
REQ-030 ALU SHALL set ALUop to 00 for ADD and MOV, 10 for AND, 11 for MVN.
REQ-031 CMPS SHALL assert loads=1, ALUop=01, asel=0, bsel=0, shift=sh.
REQ-032 WREG SHALL assert write=1, vsel=00, writenum=Rd.
REQ-033 Any control not named for the current state SHALL be 0; readnum and writenum SHALL be 000 outside the states above.
REQ-034 Clock edges from s sampled in WAIT to w=1 SHALL be: MOV imm 3, MOV reg/MVN/CMP 5, ADD/AND 6, illegal 2.
REQ-035 s, and load_ir, asserted while w=0 SHALL be ignored, and IR SHALL hold.
REQ-036 load_ir and s high on the same WAIT edge SHALL capture IR and enter DECODE; the new IR SHALL be executed.
REQ-037 s held high SHALL restart immediately on re-entering WAIT (back-to-back execution of the same IR).
REQ-038 sximm8 and sximm5 SHALL track IR continuously.

Reset
REQ-039 When reset_n=0 at a clock edge, the block SHALL enter WAIT and set IR to 0x0000, from any state including mid-instruction.
REQ-040 After reset, all outputs SHALL be 0 except w=1; no partial write SHALL complete after reset.

Verification
REQ-041 Load 0xD0FF, pulse s -> in WIMM: write=1, vsel=10, writenum=0, sximm8=0xFFFF; w=1 after 3 edges.
REQ-042 Load 0xA148 (ADD R2,R1,R0 LSL1) -> sequence GETA(readnum=1), GETB(readnum=0), ALU(ALUop=00, shift=01, loadc), WREG(writenum=2, write); w=1 after 6 edges.
REQ-043 Load 0xA902 (CMP R1,R2) -> loads=1 with ALUop=01 in CMPS; write never asserted; w=1 after 5 edges.
REQ-044 Load 0xB861 (MVN R3,R1) -> GETB readnum=1, ALU ALUop=11, WREG writenum=3; load 0x0000 -> DECODE then WAIT with no enables.
REQ-045 Assert reset_n=0 while in ALU during an ADD -> next edge w=1, IR=0x0000, write never asserted.
REQ-046 Pulse load_ir with 0xD001 while executing ADD -> ADD completes unchanged and IR still holds 0xA148.
